capp_sequencer: RTL and testbench

Command sequencer for the content-addressable parallel processor array. It accepts search, refine, masked-write and select-first commands over a valid/ready port. It drives comparand/mask/search/write strobes into the match-line and tag datapath, and owns the tag register that selects responders. It returns one response per command, giving the hit flag and resolved cell index, to the host-side controller.

---
 rtl/capp_sequencer_if.sv | 35 +++
 rtl/capp_sequencer.sv | 133 +++++++++++++
 tb/tb_capp_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/capp_sequencer_if.sv
// Command, response and array-strobe bundle between the host controller,
// the CAPP array datapath and the command sequencer.
interface capp_sequencer_if #(
    parameter int CELLS = 4096,
    parameter int WIDTH = 32,
    parameter int IDX_W = 12
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_comparand;
    logic [WIDTH-1:0] cmd_mask;
    logic [WIDTH-1:0] cam_comparand;
    logic [WIDTH-1:0] cam_mask;
    logic             cam_search;
    logic             cam_write;
    logic [CELLS-1:0] cam_tag_en;
    logic [CELLS-1:0] tag_in;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_hit;
    logic [IDX_W-1:0] rsp_index;

    // slave: the sequencer; master: host plus array side
    modport slave (
        input  cmd_valid, cmd_op, cmd_comparand, cmd_mask, tag_in, rsp_ready,
        output cmd_ready, cam_comparand, cam_mask, cam_search, cam_write,
               cam_tag_en, rsp_valid, rsp_hit, rsp_index
    );
    modport master (
        output cmd_valid, cmd_op, cmd_comparand, cmd_mask, tag_in, rsp_ready,
        input  cmd_ready, cam_comparand, cam_mask, cam_search, cam_write,
               cam_tag_en, rsp_valid, rsp_hit, rsp_index
    );
endinterface

// File: rtl/capp_sequencer.sv
// CAPP command sequencer: issues search/write strobes, owns the responder
// tag register and resolves select-first by scanning it SCAN_W bits a cycle.
module capp_sequencer #(
    parameter int CELLS      = 4096,
    parameter int WIDTH      = 32,
    parameter int SEARCH_LAT = 2,
    parameter int SCAN_W     = 64,
    parameter int IDX_W      = 12
) (
    input  logic             CLK,
    input  logic             RST_N,
    capp_sequencer_if.slave  bus
);
    localparam int NCHUNK = CELLS / SCAN_W;
    localparam int CK_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int LAT_W  = (SEARCH_LAT > 1) ? $clog2(SEARCH_LAT) : 1;
    localparam int SW_W   = (SCAN_W > 1) ? $clog2(SCAN_W) : 1;

    localparam logic [1:0] OP_SEARCH = 2'b00;
    localparam logic [1:0] OP_AND    = 2'b01;
    localparam logic [1:0] OP_WRITE  = 2'b10;
    localparam logic [1:0] OP_FIRST  = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_SCAN, S_RESP} state_t;
    state_t state, state_nxt;

    logic [1:0]       op_q;
    logic [CELLS-1:0] tag_reg, tag_cap;
    logic [LAT_W-1:0] lat_cnt;
    logic [CK_W-1:0]  chunk_k;
    logic [SCAN_W-1:0] chunk, chunk_lsb;
    logic [SW_W-1:0]  chunk_j;
    logic             chunk_any, scan_last, accept, capture, is_search;
    logic [WIDTH-1:0] comparand_q, mask_q;
    logic             search_q, write_q, hit_q;
    logic [IDX_W-1:0] index_q;

    assign accept    = bus.cmd_valid && (state == S_IDLE);
    assign is_search = (op_q == OP_SEARCH) || (op_q == OP_AND);
    // With a one-cycle array latency the capture happens in ISSUE itself
    assign capture   = is_search &&
                       (((state == S_ISSUE) && (SEARCH_LAT == 1)) ||
                        ((state == S_WAIT) && (lat_cnt == LAT_W'(SEARCH_LAT - 2))));
    assign tag_cap   = (op_q == OP_AND) ? (tag_reg & bus.tag_in) : bus.tag_in;

    assign chunk     = tag_reg[chunk_k*SCAN_W +: SCAN_W];
    assign chunk_lsb = chunk & (~chunk + 1'b1);
    assign chunk_any = |chunk;
    assign scan_last = (chunk_k == CK_W'(NCHUNK - 1));

    always_comb begin
        chunk_j = '0;
        for (int i = SCAN_W - 1; i >= 0; i--)
            if (chunk[i]) chunk_j = SW_W'(i);
    end

    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) state <= S_IDLE;
        else        state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.cmd_valid)
                         state_nxt = (bus.cmd_op == OP_FIRST) ? S_SCAN : S_ISSUE;
            S_ISSUE: state_nxt = ((op_q == OP_WRITE) || (SEARCH_LAT == 1)) ? S_RESP : S_WAIT;
            S_WAIT:  if (capture) state_nxt = S_RESP;
            S_SCAN:  if (chunk_any || scan_last) state_nxt = S_RESP;
            S_RESP:  if (bus.rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready = (state == S_IDLE);
        bus.rsp_valid = (state == S_RESP);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            op_q        <= OP_SEARCH;
            comparand_q <= '0;
            mask_q      <= '0;
            search_q    <= 1'b0;
            write_q     <= 1'b0;
            hit_q       <= 1'b0;
            index_q     <= '0;
            tag_reg     <= '0;
            lat_cnt     <= '0;
            chunk_k     <= '0;
        end else begin
            search_q <= 1'b0;
            write_q  <= 1'b0;
            if (accept) begin
                op_q        <= bus.cmd_op;
                comparand_q <= bus.cmd_comparand;
                mask_q      <= bus.cmd_mask;
                // strobes registered here so they land exactly in the ISSUE cycle
                search_q    <= (bus.cmd_op == OP_SEARCH) || (bus.cmd_op == OP_AND);
                write_q     <= (bus.cmd_op == OP_WRITE);
                index_q     <= '0;
                lat_cnt     <= '0;
                chunk_k     <= '0;
            end
            if ((state == S_ISSUE) && (op_q == OP_WRITE)) hit_q <= |tag_reg;
            if (state == S_WAIT) lat_cnt <= lat_cnt + 1'b1;
            if (capture) begin
                tag_reg <= tag_cap;
                hit_q   <= |tag_cap;
            end
            if (state == S_SCAN) begin
                if (chunk_any) begin
                    index_q <= IDX_W'(int'(chunk_k) * SCAN_W + int'(chunk_j));
                    hit_q   <= 1'b1;
                    tag_reg[chunk_k*SCAN_W +: SCAN_W] <= chunk & ~chunk_lsb;
                end else if (scan_last) begin
                    index_q <= '0;
                    hit_q   <= 1'b0;
                end else begin
                    chunk_k <= chunk_k + 1'b1;
                end
            end
        end
    end

    assign bus.cam_comparand = comparand_q;
    assign bus.cam_mask      = mask_q;
    assign bus.cam_search    = search_q;
    assign bus.cam_write     = write_q;
    assign bus.cam_tag_en    = tag_reg;
    assign bus.rsp_hit       = hit_q;
    assign bus.rsp_index     = index_q;
endmodule

// File: tb/tb_capp_sequencer.sv
// Self-checking bench for capp_sequencer: directed cases plus random commands
// scored against a cell-level model of the tag register.
module tb_capp_sequencer;
    localparam int CELLS = 4096, WIDTH = 32, SEARCH_LAT = 2, SCAN_W = 64, IDX_W = 12;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    capp_sequencer_if #(.CELLS(CELLS), .WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();

    capp_sequencer #(.CELLS(CELLS), .WIDTH(WIDTH), .SEARCH_LAT(SEARCH_LAT),
                     .SCAN_W(SCAN_W), .IDX_W(IDX_W))
        dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));

    int errors = 0;
    int checks = 0;
    logic [CELLS-1:0] model_tag;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [CELLS-1:0] onehot(input int i);
        logic [CELLS-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [CELLS-1:0] sparse(input int nbits);
        logic [CELLS-1:0] v;
        v = '0;
        for (int i = 0; i < nbits; i++) v[$urandom_range(0, CELLS-1)] = 1'b1;
        return v;
    endfunction

    function automatic logic [CELLS-1:0] noise();
        logic [CELLS-1:0] v;
        for (int i = 0; i < CELLS/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Entered and left at a falling edge. tin is presented only in the cycle
    // the array result is due; every other cycle carries noise.
    task automatic do_cmd(input logic [1:0] op, input logic [31:0] comp, input logic [31:0] mask,
                          input logic [CELLS-1:0] tin, input int hold, input bit offer);
        int lat, n, ns, nw, fs, fw, idx;
        logic hit;
        idx = 0; hit = 1'b0;
        case (op)
            2'd0: begin model_tag = tin; hit = |model_tag; lat = SEARCH_LAT + 1; end
            2'd1: begin model_tag = model_tag & tin; hit = |model_tag; lat = SEARCH_LAT + 1; end
            2'd2: begin hit = |model_tag; lat = 2; end
            default: begin
                lat = 1 + CELLS/SCAN_W;
                for (int i = 0; i < CELLS; i++)
                    if (!hit && model_tag[i]) begin
                        hit = 1'b1; idx = i; lat = 2 + i/SCAN_W;
                    end
                if (hit) model_tag[idx] = 1'b0;
            end
        endcase

        bus.cmd_valid = 1'b1; bus.cmd_op = op;
        bus.cmd_comparand = comp; bus.cmd_mask = mask;
        bus.tag_in = noise();
        chk("cmd_ready_idle", bus.cmd_ready, 1);
        @(posedge CLK);
        @(negedge CLK);
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'($urandom);
        bus.cmd_comparand = $urandom; bus.cmd_mask = $urandom;
        n = 1; ns = 0; nw = 0; fs = 0; fw = 0;
        forever begin
            bus.tag_in = (n == SEARCH_LAT) ? tin : noise();
            if (bus.cam_search) begin ns++; if (fs == 0) fs = n; end
            if (bus.cam_write)  begin nw++; if (fw == 0) fw = n; end
            if (bus.rsp_valid || n > CELLS/SCAN_W + SEARCH_LAT + 8) break;
            @(negedge CLK);
            n++;
        end
        chk("rsp_latency", n, lat);
        chk("rsp_valid", bus.rsp_valid, 1);
        chk("rsp_hit", bus.rsp_hit, hit);
        chk("rsp_index", bus.rsp_index, idx);
        chk("cam_tag_en", bus.cam_tag_en == model_tag, 1);
        chk("cam_comparand", bus.cam_comparand, comp);
        chk("cam_mask", bus.cam_mask, mask);
        chk("search_pulses", ns, (op < 2) ? 1 : 0);
        chk("search_cycle", fs, (op < 2) ? 1 : 0);
        chk("write_pulses", nw, (op == 2) ? 1 : 0);
        chk("write_cycle", fw, (op == 2) ? 1 : 0);

        if (offer) begin
            bus.cmd_valid = 1'b1; bus.cmd_op = 2'b10;
            bus.cmd_comparand = 32'h1234_5678; bus.cmd_mask = 32'h0F0F_0F0F;
        end
        repeat (hold) begin
            @(negedge CLK);
            chk("hold_valid", bus.rsp_valid, 1);
            chk("hold_hit", bus.rsp_hit, hit);
            chk("hold_index", bus.rsp_index, idx);
            chk("hold_cmd_ready", bus.cmd_ready, 0);
            chk("hold_comparand", bus.cam_comparand, comp);
        end
        bus.rsp_ready = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        bus.rsp_ready = 1'b0;
        chk("rsp_released", bus.rsp_valid, 0);
        chk("cmd_ready_back", bus.cmd_ready, 1);
        chk("cam_comparand_kept", bus.cam_comparand, comp);
        chk("tag_after", bus.cam_tag_en == model_tag, 1);
    endtask

    initial begin
        bit saw_valid;
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00;
        bus.cmd_comparand = '0; bus.cmd_mask = '0;
        bus.tag_in = '0; bus.rsp_ready = 1'b0;
        model_tag = '0;

        repeat (3) @(negedge CLK);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_search", bus.cam_search, 0);
        chk("rst_write", bus.cam_write, 0);
        chk("rst_hit", bus.rsp_hit, 0);
        chk("rst_index", bus.rsp_index, 0);
        chk("rst_comparand", bus.cam_comparand, 0);
        chk("rst_mask", bus.cam_mask, 0);
        chk("rst_tag", bus.cam_tag_en == '0, 1);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("rst_cmd_ready", bus.cmd_ready, 1);

        // search, then select-first walk over {3,4000} and the miss case
        do_cmd(2'd0, 32'h0000_00A5, 32'h0000_00FF, onehot(3) | onehot(4000), 0, 0);
        do_cmd(2'd3, $urandom, $urandom, '0, 0, 0);
        do_cmd(2'd3, $urandom, $urandom, '0, 0, 0);
        do_cmd(2'd3, $urandom, $urandom, '0, 0, 0);
        // refine chain
        do_cmd(2'd0, 32'h0000_00A5, 32'h0000_00FF, onehot(3) | onehot(4000), 0, 0);
        do_cmd(2'd1, $urandom, $urandom, onehot(4000), 0, 0);
        do_cmd(2'd1, $urandom, $urandom, '0, 0, 0);
        // masked write with backpressure and a command offered during it
        do_cmd(2'd0, $urandom, $urandom, onehot(7), 0, 0);
        do_cmd(2'd2, 32'hDEAD_BEEF, 32'hFFFF_0000, '0, 10, 1);
        do_cmd(2'd2, 32'h1234_5678, 32'h0F0F_0F0F, '0, 0, 0);
        do_cmd(2'd0, $urandom, $urandom, '0, 0, 0);
        do_cmd(2'd2, $urandom, $urandom, '0, 0, 0);

        // reset while scanning chunk 20
        do_cmd(2'd0, $urandom, $urandom, onehot(3000), 0, 0);
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'b11;
        bus.cmd_comparand = 32'hCAFE_F00D; bus.cmd_mask = 32'hFFFF_FFFF;
        @(posedge CLK);
        @(negedge CLK);
        bus.cmd_valid = 1'b0;
        repeat (20) @(negedge CLK);
        RST_N = 1'b0;
        #1;
        chk("arst_rsp_valid", bus.rsp_valid, 0);
        chk("arst_hit", bus.rsp_hit, 0);
        chk("arst_index", bus.rsp_index, 0);
        chk("arst_comparand", bus.cam_comparand, 0);
        chk("arst_mask", bus.cam_mask, 0);
        chk("arst_search", bus.cam_search, 0);
        chk("arst_write", bus.cam_write, 0);
        chk("arst_tag", bus.cam_tag_en == '0, 1);
        model_tag = '0;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        saw_valid = 1'b0;
        repeat (70) begin
            @(negedge CLK);
            if (bus.rsp_valid) saw_valid = 1'b1;
        end
        chk("arst_no_rsp", saw_valid, 0);
        chk("arst_cmd_ready", bus.cmd_ready, 1);

        for (int k = 0; k < 40; k++)
            do_cmd(2'($urandom_range(0, 3)), $urandom, $urandom,
                   sparse($urandom_range(0, 4)), $urandom_range(0, 3), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
